// File: rtl/aes_sbox_core.sv
// Byte-wide AES S-box: forward and inverse substitution as GF(2^8) inversion plus affine maps,
// with one registered copy of the forward result.
module aes_sbox_core (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] a,
   output logic [7:0] y,
   output logic [7:0] y_inv,
   output logic [7:0] y_q
);

   logic [7:0] y_d;

   // Multiply modulo x^8+x^4+x^3+x+1, reducing after each shift of the multiplicand
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p;
      logic [7:0] m;
      logic [7:0] n;
      p = 8'h00;
      m = x;
      n = z;
      for (int i = 0; i < 8; i++) begin
         if (n[0]) begin
            p = p ^ m;
         end else begin
            p = p;
         end
         if (m[7]) begin
            m = {m[6:0], 1'b0} ^ 8'h1B;
         end else begin
            m = {m[6:0], 1'b0};
         end
         n = {1'b0, n[7:1]};
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse for x != 0 and naturally yields 0 for x == 0
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] s;
      r = 8'h01;
      s = x;
      for (int i = 0; i < 7; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r;
   endfunction

   // Rotate-left by k puts bit (i+8-k)%8 into bit i, matching the affine tap offsets
   function automatic logic [7:0] fwd_affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_affine(input logic [7:0] b);
      return {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ 8'h05;
   endfunction

   // Both substitutions are pure functions of a; the register input mirrors the forward result
   always_comb begin
      y     = fwd_affine(gf_inv(a));
      y_inv = gf_inv(inv_affine(a));
      y_d   = y;
   end

   // Pipelined copy of the forward substitution, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= 8'h00;
      end else begin
         y_q <= y_d;
      end
   end

endmodule

// File: tb/tb_aes_sbox_core.sv
// Self-checking bench for aes_sbox_core: spec-level GF(2^8) model built by polynomial
// arithmetic and brute-force inversion, directed spot vectors, sweep and register checks.
module tb_aes_sbox_core;

   logic       clk;
   logic       rst_n;
   logic [7:0] a;
   logic [7:0] y, y_inv, y_q;
   logic [7:0] y2, y2_inv, y2_q;

   int tests = 0;
   int fails = 0;
   bit model_ready = 1'b0;
   logic [7:0] model_s   [256];
   logic [7:0] model_inv [256];
   logic [7:0] exp_q;
   bit seen [256];

   aes_sbox_core u_dut (
      .clk(clk), .rst_n(rst_n), .a(a), .y(y), .y_inv(y_inv), .y_q(y_q)
   );

   // Second instance undoes the first: its input is the first instance's forward output
   aes_sbox_core u_dut2 (
      .clk(clk), .rst_n(rst_n), .a(y), .y(y2), .y_inv(y2_inv), .y_q(y2_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Full polynomial product, then reduction modulo 0x11B
   function automatic int m_mul(input int x, input int z);
      int p;
      p = 0;
      for (int i = 0; i < 8; i++)
         if (((z >> i) & 1) == 1) p = p ^ (x << i);
      for (int k = 14; k >= 8; k--)
         if (((p >> k) & 1) == 1) p = p ^ (32'h11B << (k - 8));
      return p;
   endfunction

   function automatic int m_inv(input int x);
      int r;
      r = 0;
      for (int j = 1; j < 256; j++)
         if (m_mul(x, j) == 1) r = j;
      return r;
   endfunction

   function automatic int bitof(input int v, input int i);
      return (v >> (i % 8)) & 1;
   endfunction

   function automatic int m_fwd(input int x);
      int b, r;
      b = m_inv(x);
      r = 0;
      for (int i = 0; i < 8; i++)
         r = r | ((bitof(b, i) ^ bitof(b, i + 4) ^ bitof(b, i + 5) ^ bitof(b, i + 6)
                   ^ bitof(b, i + 7) ^ bitof(32'h63, i)) << i);
      return r;
   endfunction

   function automatic int m_bwd(input int x);
      int t;
      t = 0;
      for (int i = 0; i < 8; i++)
         t = t | ((bitof(x, i + 2) ^ bitof(x, i + 5) ^ bitof(x, i + 7) ^ bitof(32'h05, i)) << i);
      return m_inv(t);
   endfunction

   // Expected registered value: capture S(a) at each rising edge, clear on reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) exp_q <= 8'h00;
      else        exp_q <= model_s[a];
   end

   // Compare process: every falling edge all outputs must agree with the model
   always @(negedge clk) begin
      if (model_ready) begin
         check("cyc_y", y, model_s[a]);
         check("cyc_y_inv", y_inv, model_inv[a]);
         check("cyc_roundtrip", y2_inv, a);
         check("cyc_y_q", y_q, exp_q);
      end
   end

   task automatic apply(input logic [7:0] v);
      @(posedge clk);
      #2 a = v;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      a     = 8'h00;
      for (int i = 0; i < 256; i++) begin
         model_s[i]   = 8'(m_fwd(i));
         model_inv[i] = 8'(m_bwd(i));
         seen[i]      = 1'b0;
      end
      model_ready = 1'b1;

      // Pin the model against known FIPS-197 entries
      check("model_s_00", model_s[8'h00], 8'h63);
      check("model_s_53", model_s[8'h53], 8'hED);
      check("model_inv_00", model_inv[8'h00], 8'h52);

      // Combinational spot checks, 1 ns after a changes, reset still asserted
      #1 a = 8'h00; #1 check("y_00", y, 8'h63);
      a = 8'h53; #1 check("y_53", y, 8'hED);
      a = 8'hFF; #1 check("y_FF", y, 8'h16);
      a = 8'h01; #1 check("y_01", y, 8'h7C);
      a = 8'hC9; #1 check("y_C9", y, 8'hDD);
      a = 8'h63; #1 check("yinv_63", y_inv, 8'h00);
      a = 8'hED; #1 check("yinv_ED", y_inv, 8'h53);
      a = 8'h16; #1 check("yinv_16", y_inv, 8'hFF);
      a = 8'h00; #1 check("yinv_00", y_inv, 8'h52);

      // Register held clear while in reset
      apply(8'h53);
      @(posedge clk); #1 check("yq_in_reset", y_q, 8'h00);

      // Release reset, then capture
      #1 rst_n = 1'b1;
      apply(8'h53);
      @(posedge clk); #1 check("yq_first", y_q, 8'hED);
      #1 a = 8'h00;
      #1 check("yq_hold", y_q, 8'hED);
      @(posedge clk); #1 check("yq_next", y_q, 8'h63);

      // Asynchronous reset between edges
      apply(8'h53);
      @(posedge clk); #1 check("yq_pre_rst", y_q, 8'hED);
      #1 rst_n = 1'b0;
      #1 check("yq_async_clr", y_q, 8'h00);
      check("y_during_rst", y, 8'hED);
      @(posedge clk); #1 check("yq_rst_held", y_q, 8'h00);
      #1 rst_n = 1'b1;

      // Exhaustive sweep: table, round trip, fixed points, bijection
      for (int x = 0; x < 256; x++) begin
         apply(8'(x));
         check("sweep_y", y, model_s[x]);
         check("sweep_roundtrip", y2_inv, 8'(x));
         tests++;
         if (y === 8'(x) || y === ~8'(x)) begin
            fails++;
            $display("FAIL fixed_point: a=%h y=%h", a, y);
         end
         tests++;
         if (seen[y]) begin
            fails++;
            $display("FAIL bijection: y=%h repeated at a=%h", y, a);
         end
         seen[y] = 1'b1;
      end

      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
